// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte-addressed data memory with req/rsp handshake
// Little-endian byte/half/word access, sign/zero-extended loads, 1- or 2-cycle read latency.
module data_memory_sized #(
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int INIT_PATTERN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef logic [31:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = (INIT_PATTERN == 1) ? 32'(i) : 32'd0;
        end
        return m;
    endfunction

    // Contents are set once at time zero and deliberately survive reset.
    mem_t mem_q = init_mem();

    state_t      state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] pend_rdata_q, pend_rdata_d;
    logic        pend_err_q, pend_err_d;

    logic             accept;
    logic             in_range;
    logic             acc_err;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_val;
    logic [31:0]      acc_rdata;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wd;

    assign req_ready = (state_q == IDLE) || (state_q == RESP && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign in_range = req_addr[ADDR_W-1:2] < DEPTH_L;
    assign mem_idx  = req_addr[IDX_W+1:2];
    assign rd_word  = mem_q[mem_idx];
    assign rd_byte  = rd_word[{req_addr[1:0], 3'b000} +: 8];
    assign rd_half  = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        acc_err  = 1'b0;
        load_val = 32'd0;
        mem_be   = 4'b0000;
        mem_wd   = req_wdata;
        case (req_size)
            2'b00: begin
                load_val = req_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                mem_be   = 4'b0001 << req_addr[1:0];
                mem_wd   = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                acc_err  = req_addr[0];
                load_val = req_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
                mem_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                mem_wd   = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                acc_err  = (req_addr[1:0] != 2'b00);
                load_val = rd_word;
                mem_be   = 4'b1111;
            end
            default: acc_err = 1'b1;
        endcase
        if (!in_range) begin
            acc_err = 1'b1;
        end
        acc_rdata = (req_write || acc_err) ? 32'd0 : load_val;
        mem_we    = accept && req_write && !acc_err;
    end

    // Store commits at the accept edge so a load accepted next cycle sees it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        pend_rdata_d = pend_rdata_q;
        pend_err_d   = pend_err_q;
        if (state_q == RESP && rsp_ready) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b0;
        end
        case (state_q)
            WAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = pend_rdata_q;
                rsp_err_d   = pend_err_q;
            end
            IDLE, RESP: begin
                if (accept) begin
                    if (READ_LATENCY == 2) begin
                        state_d      = WAIT;
                        pend_rdata_d = acc_rdata;
                        pend_err_d   = acc_err;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = acc_rdata;
                        rsp_err_d   = acc_err;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            rsp_err_q    <= 1'b0;
            pend_rdata_q <= 32'd0;
            pend_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            pend_rdata_q <= pend_rdata_d;
            pend_err_q   <= pend_err_d;
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - directed bench for data_memory_sized
// Two instances share all inputs: u_lat1 (READ_LATENCY=1) and u_lat2 (READ_LATENCY=2).
module tb_data_memory_sized;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        r1_req_ready, r1_rsp_valid, r1_rsp_err;
    logic [31:0] r1_rsp_rdata;
    logic        r2_req_ready, r2_rsp_valid, r2_rsp_err;
    logic [31:0] r2_rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_sized #(.DEPTH(256), .ADDR_W(32), .READ_LATENCY(1), .INIT_PATTERN(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r1_req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r1_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(r1_rsp_rdata), .rsp_err(r1_rsp_err)
    );

    data_memory_sized #(.DEPTH(256), .ADDR_W(32), .READ_LATENCY(2), .INIT_PATTERN(1)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r2_req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r2_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(r2_rsp_rdata), .rsp_err(r2_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "/r1_req_ready"}, 32'(r1_req_ready), 32'd1);
        check({tag, "/r1_rsp_valid"}, 32'(r1_rsp_valid), 32'd0);
        check({tag, "/r1_rdata"}, r1_rsp_rdata, 32'd0);
        check({tag, "/r1_err"}, 32'(r1_rsp_err), 32'd0);
        check({tag, "/r2_req_ready"}, 32'(r2_req_ready), 32'd1);
        check({tag, "/r2_rsp_valid"}, 32'(r2_rsp_valid), 32'd0);
        check({tag, "/r2_rdata"}, r2_rsp_rdata, 32'd0);
        check({tag, "/r2_err"}, 32'(r2_rsp_err), 32'd0);
    endtask

    // Called just after a rising edge with both instances idle; returns just after a rising edge.
    task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err);
        rsp_ready = 1'b1;
        drive(w, sz, uns, a, wd);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check({tag, "/lat1_valid"}, 32'(r1_rsp_valid), 32'd1);
        check({tag, "/lat1_rdata"}, r1_rsp_rdata, exp_rdata);
        check({tag, "/lat1_err"}, 32'(r1_rsp_err), 32'(exp_err));
        check({tag, "/lat2_wait"}, 32'(r2_rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "/lat2_valid"}, 32'(r2_rsp_valid), 32'd1);
        check({tag, "/lat2_rdata"}, r2_rsp_rdata, exp_rdata);
        check({tag, "/lat2_err"}, 32'(r2_rsp_err), 32'(exp_err));
        check({tag, "/lat1_done"}, 32'(r1_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        xact("t1_ld_w10", 1'b0, 2'b10, 1'b1, 32'h10, 32'd0, 32'h0000_0004, 1'b0);

        xact("t2_st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h8180_7F01, 32'd0, 1'b0);
        xact("t2_ld_b22s", 1'b0, 2'b00, 1'b0, 32'h22, 32'd0, 32'hFFFF_FF80, 1'b0);
        xact("t2_ld_b22u", 1'b0, 2'b00, 1'b1, 32'h22, 32'd0, 32'h0000_0080, 1'b0);
        xact("t2_ld_h20s", 1'b0, 2'b01, 1'b0, 32'h20, 32'd0, 32'h0000_7F01, 1'b0);
        xact("t2_ld_h22s", 1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 32'hFFFF_8180, 1'b0);

        xact("t3_st_b31", 1'b1, 2'b00, 1'b0, 32'h31, 32'h1234_56AA, 32'd0, 1'b0);
        xact("t3_ld_w30", 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 32'h0000_AA0C, 1'b0);

        xact("t4_ld_w22", 1'b0, 2'b10, 1'b0, 32'h22, 32'd0, 32'd0, 1'b1);
        xact("t4_st_h41", 1'b1, 2'b01, 1'b0, 32'h41, 32'hFFFF_FFFF, 32'd0, 1'b1);
        xact("t4_ld_w40", 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'h0000_0010, 1'b0);
        xact("t4_ld_oor", 1'b0, 2'b10, 1'b0, 32'h400, 32'd0, 32'd0, 1'b1);
        xact("t4_ld_last", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, 32'h0000_00FF, 1'b0);
        xact("t4_ld_hibit", 1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'd0, 32'd0, 1'b1);
        xact("t4_size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1);

        // Backpressure: response held for 5 cycles, then back-to-back accept.
        rsp_ready = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", 32'(r1_rsp_valid), 32'd1);
            check("t5_hold_rdata", r1_rsp_rdata, 32'h0000_0004);
            check("t5_hold_ready", 32'(r1_req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t5_lat2_held", r2_rsp_rdata, 32'h0000_0004);
        check("t5_lat2_ready", 32'(r2_req_ready), 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drive(1'b0, 2'b10, 1'b0, 32'h14, 32'd0);
        #1;
        check("t5_b2b_ready1", 32'(r1_req_ready), 32'd1);
        check("t5_b2b_ready2", 32'(r2_req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("t5_b2b_valid1", 32'(r1_rsp_valid), 32'd1);
        check("t5_b2b_rdata1", r1_rsp_rdata, 32'h0000_0005);
        check("t5_b2b_wait2", 32'(r2_rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t5_b2b_valid2", 32'(r2_rsp_valid), 32'd1);
        check("t5_b2b_rdata2", r2_rsp_rdata, 32'h0000_0005);
        @(posedge clk);
        #1;

        // Store then load on the very next cycle: only the 1-cycle instance is ready for it.
        drive(1'b1, 2'b10, 1'b0, 32'h60, 32'h1122_3344);
        @(posedge clk);
        #1 drive(1'b0, 2'b10, 1'b0, 32'h60, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("ord_lat1_valid", 32'(r1_rsp_valid), 32'd1);
        check("ord_lat1_rdata", r1_rsp_rdata, 32'h1122_3344);
        check("ord_lat2_ack", r2_rsp_rdata, 32'd0);
        check("ord_lat2_valid", 32'(r2_rsp_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("ord_lat2_noacc", 32'(r2_rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset while the 2-cycle instance is in WAIT.
        xact("t6_st_w50", 1'b1, 2'b10, 1'b0, 32'h50, 32'hDEAD_BEEF, 32'd0, 1'b0);
        drive(1'b0, 2'b10, 1'b0, 32'h50, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid2", 32'(r2_rsp_valid), 32'd0);
        check("t6_rst_valid1", 32'(r1_rsp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("t6_rst_still2", 32'(r2_rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("t6_after_rst");
        @(posedge clk);
        #1;
        xact("t6_ld_w50", 1'b0, 2'b10, 1'b0, 32'h50, 32'd0, 32'hDEAD_BEEF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
